// File: rtl/logic_engine_pkg.sv
// Shared definitions for the 8-bit logic engine and its request issuer:
// opcode encodings, the default datapath width and the request record.
package logic_engine_pkg;

    localparam int LOGIC_WIDTH = 8;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_AND  = 2'b11;

    // One queued operation; chain=1 means "use the last captured result as B".
    typedef struct packed {
        logic [LOGIC_WIDTH-1:0] a;
        logic [LOGIC_WIDTH-1:0] b;
        logic [1:0]             opcode;
        logic                   chain;
    } logic_req_t;

endpackage

// File: rtl/logic_req_fifo.sv
// Small synchronous FIFO of request records. The head entry is read
// combinationally so the issuer can drive the engine from it directly.
module logic_req_fifo
    import logic_engine_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type req_t = logic_req_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  req_t                         push_data,
    input  logic                         pop,
    output req_t                         head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    req_t             mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/logic_op_issuer.sv
// Upstream feeder for the combinational logic engine: buffers requests,
// presents the head entry on eng_*, and captures the engine result into a
// registered valid/ready output stage. Supports chaining B from the last result.
// Optional: define LOGIC_ISSUE_PARITY_EN to add the registered out_parity port.
module logic_op_issuer
    import logic_engine_pkg::*;
#(
    parameter int WIDTH = LOGIC_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_opcode,
    input  logic             in_chain,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_b,
    output logic [1:0]       eng_opcode,
    input  logic [WIDTH-1:0] eng_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
`ifdef LOGIC_ISSUE_PARITY_EN
    output logic             out_parity,
`endif
    output logic [1:0]       out_opcode
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Width-local request record so WIDTH other than the package default works.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       opcode;
        logic             chain;
    } req_t;

    req_t             push_req;
    req_t             head_req;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             issue;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_result_reg;
    logic [1:0]       out_opcode_reg;
    logic [WIDTH-1:0] last_result_reg;

    assign push_req = '{a: in_a, b: in_b, opcode: in_opcode, chain: in_chain};

    // in_ready depends on occupancy only; a same-cycle pop does not free a slot early.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign issue    = !fifo_empty && (!out_valid_reg || out_ready);

    logic_req_fifo #(
        .DEPTH (DEPTH),
        .req_t (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (issue),
        .head      (head_req),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Engine drive: head entry, with B optionally replaced by the last result; zero when idle.
    always_comb begin
        eng_a      = '0;
        eng_b      = '0;
        eng_opcode = '0;
        if (!fifo_empty) begin
            eng_a      = head_req.a;
            eng_b      = head_req.chain ? last_result_reg : head_req.b;
            eng_opcode = head_req.opcode;
        end
    end

    // Output register and chaining state: capture on issue, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_result_reg  <= '0;
            out_opcode_reg  <= '0;
            last_result_reg <= '0;
        end else if (issue) begin
            out_valid_reg   <= 1'b1;
            out_result_reg  <= eng_result;
            out_opcode_reg  <= head_req.opcode;
            last_result_reg <= eng_result;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg   <= 1'b0;
        end
    end

`ifdef LOGIC_ISSUE_PARITY_EN
    logic out_parity_reg;

    // Parity of the captured result, updated in lockstep with out_result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity_reg <= 1'b0;
        end else if (issue) begin
            out_parity_reg <= ^eng_result;
        end
    end

    assign out_parity = out_parity_reg;
`endif

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_opcode = out_opcode_reg;

endmodule
